// File: rtl/sme_multi.sv
// sme_multi: parametrised string-match engine with '.', '^', '$' and a find-all mode.
// Stores one string, then searches each following pattern against it, one candidate per cycle.
module sme_multi #(
  parameter int CW = 8,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int IDXW = $clog2(STR_MAX)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CW-1:0]   chardata,
  input  logic            isstring,
  input  logic            ispattern,
  input  logic            mode_all,
  output logic            busy,
  output logic            valid,
  output logic            match,
  output logic [IDXW-1:0] match_index,
  output logic            last
);
  localparam int LW = $clog2(STR_MAX + 1);
  localparam int PW = $clog2(PAT_MAX + 1);
  localparam int KW = $clog2(STR_MAX + PAT_MAX + 4) + 1;
  localparam int SW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int QW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam logic [2:0] IDLE = 3'd0, LOAD_STR = 3'd1, LOAD_PAT = 3'd2, SEARCH = 3'd3, DRAIN = 3'd4;
  localparam logic [CW-1:0] SP = CW'(8'h20), CARET = CW'(8'h5E), DOL = CW'(8'h24), DOT = CW'(8'h2E);
  logic [2:0] st;
  logic [CW-1:0] sbuf [STR_MAX];
  logic [CW-1:0] pbuf [PAT_MAX];
  logic [LW-1:0] slen;
  logic [PW-1:0] plen;
  logic mode;
  logic signed [KW-1:0] k, kmin, kmax;
  logic anc_s, anc_e, hit, ok;
  logic [CW-1:0] c, x;
  logic str_first, str_app, pat_first, pat_app;
  assign busy = (st == SEARCH) | (st == DRAIN) | valid;
  assign str_first = !busy & (st == IDLE) & isstring & !ispattern;
  assign str_app = (st == LOAD_STR) & isstring & !ispattern & (slen < LW'(STR_MAX));
  assign pat_first = !busy & ((st == IDLE) | (st == LOAD_STR)) & ispattern;
  assign pat_app = (st == LOAD_PAT) & ispattern & (plen < PW'(PAT_MAX));
  assign anc_s = pbuf[0] == CARET;
  assign anc_e = pbuf[QW'(plen - PW'(1))] == DOL;
  assign kmin = anc_s ? '0 : KW'(1);
  assign kmax = $signed(KW'(slen) + (anc_e ? KW'(2) : KW'(1)) - KW'(plen));
  // Virtual buffer: the string framed by a space on each side.
  function automatic logic [CW-1:0] vchar(input logic signed [KW-1:0] i);
    vchar = (i == '0) ? SP : (i <= KW'(slen)) ? sbuf[SW'(i - KW'(1))] : SP;
  endfunction
  always_comb begin
    hit = 1'b1;
    c = '0;
    x = '0;
    ok = 1'b0;
    for (int j = 0; j < PAT_MAX; j++) begin
      c = pbuf[QW'(j)];
      x = vchar(k + KW'(j));
      ok = (j == 0 && c == CARET) ? (x == SP) :
           (PW'(j) == plen - PW'(1) && c == DOL) ? (x == SP) : (c == DOT) | (c == x);
      if (PW'(j) < plen && !ok) hit = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (str_first) sbuf[0] <= chardata;
    else if (str_app) sbuf[SW'(slen)] <= chardata;
    if (pat_first) pbuf[0] <= chardata;
    else if (pat_app) pbuf[QW'(plen)] <= chardata;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      slen <= '0;
      plen <= '0;
      mode <= 1'b0;
      k <= '0;
      valid <= 1'b0;
      match <= 1'b0;
      last <= 1'b0;
      match_index <= '0;
    end else begin
      valid <= 1'b0;
      match <= 1'b0;
      last <= 1'b0;
      match_index <= '0;
      case (st)
        IDLE, LOAD_STR: begin
          if (pat_first) begin
            st <= LOAD_PAT;
            plen <= PW'(1);
            mode <= mode_all;
          end else if (str_first) begin
            st <= LOAD_STR;
            slen <= LW'(1);
          end else if (str_app) slen <= slen + LW'(1);
        end
        LOAD_PAT: begin
          if (!ispattern) begin
            st <= SEARCH;
            k <= kmin;
          end else if (pat_app) plen <= plen + PW'(1);
        end
        SEARCH: begin
          if (k > kmax) begin
            valid <= 1'b1;
            last <= 1'b1;
            st <= IDLE;
          end else begin
            if (hit) begin
              valid <= 1'b1;
              match <= 1'b1;
              last <= !mode;
              match_index <= IDXW'(anc_s ? k : k - KW'(1));
            end
            if (hit && !mode) st <= IDLE;
            else if (k == kmax) begin
              if (mode) st <= DRAIN;
              else begin
                valid <= 1'b1;
                last <= 1'b1;
                st <= IDLE;
              end
            end else k <= k + KW'(1);
          end
        end
        DRAIN: begin
          valid <= 1'b1;
          last <= 1'b1;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
